// File: rtl/pdu_dbus_arbiter.sv
// PDU data-bus arbiter: shares the single PDU data master port between the
// soft-core load/store unit (m0) and the host debug/loader engine (m1).
// Round-robin grant with an optional bounded lock for bursts. Read data is
// registered and returned one cycle after the accepted transfer.
module pdu_dbus_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  output logic        m0_ack,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  output logic        m1_ack,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,

  output logic [31:0] pdu_daddr,
  output logic [31:0] pdu_dwdata,
  output logic        pdu_dwe,
  input  logic [31:0] pdu_drdata,

  output logic [1:0]  grant_id
);

  // Encoding doubles as the grant_id value.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } state_e;

  state_e      state_q;
  logic        last_owner_q;  // 0 = m0 held the bus last, 1 = m1
  logic [7:0]  burst_cnt_q;
  logic        m0_rvalid_q;
  logic        m1_rvalid_q;
  logic [31:0] m0_rdata_q;
  logic [31:0] m1_rdata_q;

  logic        xfer0;
  logic        xfer1;
  logic [8:0]  burst_next;
  logic        limit_hit;
  logic [7:0]  burst_sat;

  // Transfer qualifiers and burst-limit arithmetic.
  always_comb begin
    xfer0      = (state_q == StGnt0) && m0_req;
    xfer1      = (state_q == StGnt1) && m1_req;
    burst_next = {1'b0, burst_cnt_q} + 9'd1;
    // Compare the count including the current transfer against the limit.
    limit_hit  = burst_next >= 9'(LOCK_MAX);
    burst_sat  = (burst_cnt_q == 8'hFF) ? 8'hFF : burst_next[7:0];
  end

  // Bus mux and acks decoded from state; reset gates acks and write enable.
  always_comb begin
    pdu_daddr  = 32'd0;
    pdu_dwdata = 32'd0;
    pdu_dwe    = 1'b0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    if (xfer0) begin
      pdu_daddr  = m0_addr;
      pdu_dwdata = m0_wdata;
      pdu_dwe    = m0_we & rstn;
      m0_ack     = rstn;
    end else if (xfer1) begin
      pdu_daddr  = m1_addr;
      pdu_dwdata = m1_wdata;
      pdu_dwe    = m1_we & rstn;
      m1_ack     = rstn;
    end
    grant_id  = state_q;
    m0_rvalid = m0_rvalid_q;
    m1_rvalid = m1_rvalid_q;
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
  end

  // Grant FSM with burst counter, round-robin memory and read-return registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= 8'd0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m0_rdata_q   <= 32'd0;
      m1_rdata_q   <= 32'd0;
    end else begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          burst_cnt_q <= 8'd0;
          if (m0_req && m1_req) begin
            state_q <= last_owner_q ? StGnt0 : StGnt1;
          end else if (m0_req) begin
            state_q <= StGnt0;
          end else if (m1_req) begin
            state_q <= StGnt1;
          end
        end

        StGnt0: begin
          if (m0_req) begin
            if (!m0_we) begin
              m0_rvalid_q <= 1'b1;
              m0_rdata_q  <= pdu_drdata;
            end
            if (m1_req && (!m0_lock || limit_hit)) begin
              state_q      <= StGnt1;
              burst_cnt_q  <= 8'd0;
              last_owner_q <= 1'b0;
            end else begin
              burst_cnt_q <= burst_sat;
            end
          end else begin
            state_q      <= m1_req ? StGnt1 : StIdle;
            burst_cnt_q  <= 8'd0;
            last_owner_q <= 1'b0;
          end
        end

        StGnt1: begin
          if (m1_req) begin
            if (!m1_we) begin
              m1_rvalid_q <= 1'b1;
              m1_rdata_q  <= pdu_drdata;
            end
            if (m0_req && (!m1_lock || limit_hit)) begin
              state_q      <= StGnt0;
              burst_cnt_q  <= 8'd0;
              last_owner_q <= 1'b1;
            end else begin
              burst_cnt_q <= burst_sat;
            end
          end else begin
            state_q      <= m0_req ? StGnt0 : StIdle;
            burst_cnt_q  <= 8'd0;
            last_owner_q <= 1'b1;
          end
        end

        default: begin
          state_q     <= StIdle;
          burst_cnt_q <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdu_dbus_arbiter.sv
// Self-checking bench for pdu_dbus_arbiter: directed scenarios followed by
// randomized legal traffic, all compared against a transaction-level model.
module tb_pdu_dbus_arbiter;

  localparam int unsigned LockMax = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req[2];
  logic        lock[2];
  logic        we[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];

  logic        ack0, ack1, rv0, rv1, dwe;
  logic [31:0] rd0, rd1, daddr, dwdata, drdata;
  logic [1:0]  gid;
  logic        use_ovr;
  logic [31:0] ovr;

  always #5 clk = ~clk;

  // Decoder stand-in: read data is a fixed scramble of the address.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  assign drdata = use_ovr ? ovr : mem_rd(daddr);

  pdu_dbus_arbiter #(.LOCK_MAX(LockMax)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .m0_req     (req[0]),
    .m0_lock    (lock[0]),
    .m0_addr    (addr[0]),
    .m0_wdata   (wdata[0]),
    .m0_we      (we[0]),
    .m0_ack     (ack0),
    .m0_rvalid  (rv0),
    .m0_rdata   (rd0),
    .m1_req     (req[1]),
    .m1_lock    (lock[1]),
    .m1_addr    (addr[1]),
    .m1_wdata   (wdata[1]),
    .m1_we      (we[1]),
    .m1_ack     (ack1),
    .m1_rvalid  (rv1),
    .m1_rdata   (rd1),
    .pdu_daddr  (daddr),
    .pdu_dwdata (dwdata),
    .pdu_dwe    (dwe),
    .pdu_drdata (drdata),
    .grant_id   (gid)
  );

  // Model: owner (0 none, 1 m0, 2 m1), who owned last, transfers in this grant.
  int          own;
  int          last;
  int          run;
  logic        m_rv[2];
  logic [31:0] m_rd[2];
  logic        e_ack[2];
  logic [31:0] e_addr, e_wdata;
  logic        e_dwe;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Compare the current cycle against the model, well before the next edge.
  task automatic look();
    int m;
    #2;
    e_ack[0] = 1'b0;
    e_ack[1] = 1'b0;
    e_addr   = 32'd0;
    e_wdata  = 32'd0;
    e_dwe    = 1'b0;
    if (own != 0 && req[own-1]) begin
      m        = own - 1;
      e_addr   = addr[m];
      e_wdata  = wdata[m];
      e_dwe    = we[m] & rstn;
      e_ack[m] = rstn;
    end
    chk("grant_id", 32'(gid), 32'(own));
    chk("m0_ack", 32'(ack0), 32'(e_ack[0]));
    chk("m1_ack", 32'(ack1), 32'(e_ack[1]));
    chk("pdu_dwe", 32'(dwe), 32'(e_dwe));
    if (rstn) begin
      chk("pdu_daddr", daddr, e_addr);
      chk("pdu_dwdata", dwdata, e_wdata);
    end
    chk("m0_rvalid", 32'(rv0), 32'(m_rv[0]));
    chk("m0_rdata", rd0, m_rd[0]);
    chk("m1_rvalid", 32'(rv1), 32'(m_rv[1]));
    chk("m1_rdata", rd1, m_rd[1]);
  endtask

  // Advance the model by one clock using the arbitration rules, then the clock.
  task automatic tick();
    int me;
    int ot;
    logic [31:0] rdv;
    rdv = use_ovr ? ovr : mem_rd(e_addr);
    if (!rstn) begin
      own = 0; last = 1; run = 0;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      m_rd[0] = 32'd0; m_rd[1] = 32'd0;
    end else begin
      m_rv[0] = 1'b0;
      m_rv[1] = 1'b0;
      if (own == 0) begin
        if (req[0] && req[1]) own = (last == 1) ? 1 : 2;
        else if (req[0]) own = 1;
        else if (req[1]) own = 2;
        run = 0;
      end else begin
        me = own - 1;
        ot = 1 - me;
        if (req[me]) begin
          if (!we[me]) begin
            m_rv[me] = 1'b1;
            m_rd[me] = rdv;
          end
          run++;
          if (req[ot] && (!lock[me] || run >= int'(LockMax))) begin
            own = ot + 1; run = 0; last = me;
          end
        end else begin
          own = req[ot] ? ot + 1 : 0;
          run = 0;
          last = me;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    look();
    tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; lock[m] = 1'b0; we[m] = 1'b0;
    end
    step();
    rstn = 1'b1;
  endtask

  initial begin
    int n0;
    int first1;
    logic [31:0] r;
    checks = 0; failures = 0;
    use_ovr = 1'b0; ovr = 32'd0;
    own = 0; last = 1; run = 0;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; lock[m] = 1'b0; we[m] = 1'b0;
      addr[m] = 32'd0; wdata[m] = 32'd0;
      m_rv[m] = 1'b0; m_rd[m] = 32'd0; e_ack[m] = 1'b0;
    end
    rstn = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single read by m0 with a fixed return word.
    use_ovr = 1'b1; ovr = 32'hDEAD_BEEF;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h4000;
    step();
    look();
    chk("t1_ack", 32'(ack0), 32'd1);
    chk("t1_addr", daddr, 32'h4000);
    tick();
    req[0] = 1'b0;
    look();
    chk("t1_rvalid", 32'(rv0), 32'd1);
    chk("t1_rdata", rd0, 32'hDEAD_BEEF);
    tick();
    use_ovr = 1'b0;

    // Both masters streaming unlocked writes: strict alternation from m0.
    do_reset();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h4000; wdata[0] = 32'h1111_0000;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8100; wdata[1] = 32'h2222_0000;
    step();
    for (int i = 0; i < 6; i++) begin
      look();
      chk("t2_grant", 32'(gid), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("t2_one_ack", 32'(ack0) + 32'(ack1), 32'd1);
      chk("t2_dwe", 32'(dwe), 32'd1);
      tick();
    end

    // Locked m0 burst; m1 arrives on the first granted cycle.
    do_reset();
    req[0] = 1'b1; lock[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h4000;
    step();
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8100;
    n0 = 0; first1 = -1;
    for (int i = 0; i < 8; i++) begin
      look();
      if (first1 < 0 && ack1) first1 = i;
      if (first1 < 0 && ack0) n0++;
      tick();
    end
    chk("t3_m0_acks", 32'(n0), 32'd4);
    chk("t3_m1_latency", 32'(first1), 32'd4);

    // m0 alone: ten pipelined reads.
    do_reset();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h4000;
    step();
    for (int i = 0; i < 10; i++) begin
      addr[0] = 32'h4000 + 32'(4 * i);
      look();
      chk("t4_ack", 32'(ack0), 32'd1);
      if (i > 0) chk("t4_rdata", rd0, mem_rd(32'h4000 + 32'(4 * (i - 1))));
      tick();
    end
    req[0] = 1'b0;
    look();
    chk("t4_last_rvalid", 32'(rv0), 32'd1);
    chk("t4_last_rdata", rd0, mem_rd(32'h4024));
    tick();

    // Reset asserted during an m1 write.
    do_reset();
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8100; wdata[1] = 32'hCAFE_F00D;
    step();
    step();
    rstn = 1'b0;
    look();
    chk("t5_dwe", 32'(dwe), 32'd0);
    chk("t5_ack", 32'(ack1), 32'd0);
    tick();
    rstn = 1'b1; req[1] = 1'b0;
    look();
    chk("t5_idle", 32'(gid), 32'd0);
    tick();

    // m1 drops its request, goes idle, then re-requests.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h8200;
    step();
    step();
    req[1] = 1'b0;
    step();
    look();
    chk("t6_idle", 32'(gid), 32'd0);
    tick();
    req[1] = 1'b1;
    step();
    look();
    chk("t6_regrant", 32'(gid), 32'd2);
    chk("t6_ack", 32'(ack1), 32'd1);
    tick();
    req[1] = 1'b0;
    step();

    // Random legal traffic: requests held until acked, occasional resets.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m] && $urandom_range(0, 3) != 0) begin
          req[m]   = 1'b1;
          lock[m]  = ($urandom_range(0, 2) != 0);
          we[m]    = $urandom_range(0, 1) != 0;
          r        = $urandom();
          addr[m]  = r & 32'hFFFF_FFFC;
          wdata[m] = $urandom();
        end
      end
      rstn = ($urandom_range(0, 63) != 0);
      step();
      for (int m = 0; m < 2; m++) begin
        if (e_ack[m]) begin
          if ($urandom_range(0, 1) != 0) begin
            req[m] = 1'b0;
          end else begin
            we[m]    = $urandom_range(0, 1) != 0;
            r        = $urandom();
            addr[m]  = r & 32'hFFFF_FFFC;
            wdata[m] = $urandom();
          end
        end
      end
    end
    rstn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pdu_dbus_arbiter.md
Name: pdu_dbus_arbiter

Overview:
- Shares the single PDU data-bus master port (pdu_daddr/pdu_dwdata/pdu_dwe/pdu_drdata) between two requesters:
  - m0: the PDU soft-core load/store unit.
  - m1: the host debug/loader engine, which writes DMEM and CPU-control registers from UART commands.
- Arbitration is round-robin with an optional bounded lock for bursts.
- Read data is returned one cycle after the accepted transfer.
- Sits directly in front of the PDU address decoder.

Parameters:
- LOCK_MAX, 16: maximum consecutive transfers one locked master may take while the other master is waiting. Range 1..255.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- m0_req  in  1  m0 requests a transfer this cycle
- m0_lock  in  1  m0 asks to keep the grant after this transfer
- m0_addr  in  32  m0 byte address
- m0_wdata  in  32  m0 write data
- m0_we  in  1  m0 write enable (0 = read)
- m0_ack  out  1  m0 transfer accepted this cycle
- m0_rvalid  out  1  m0 read data valid
- m0_rdata  out  32  m0 read data
- m1_req, m1_lock, m1_addr, m1_wdata, m1_we, m1_ack, m1_rvalid, m1_rdata: same as m0, for m1
- pdu_daddr  out  32  bus address
- pdu_dwdata  out  32  bus write data
- pdu_dwe  out  1  bus write enable
- pdu_drdata  in  32  bus read data (combinational from the decoder)
- grant_id  out  2  0 = idle, 1 = m0 granted, 2 = m1 granted

Behaviour:
- Reset (rstn low at posedge): state IDLE, last_owner = m1 (so m0 wins the first tie), burst_cnt = 0.
  - All registered outputs clear: mX_rvalid = 0, mX_rdata = 0.
  - While rstn is low, pdu_dwe = 0 and mX_ack = 0 combinationally, regardless of state. A reset mid-burst aborts; no write leaks through.
- States: IDLE, GNT0, GNT1. grant_id is 0, 1 or 2 respectively. Output is decoded from state.
- IDLE:
  - pdu_daddr = 0, pdu_dwdata = 0, pdu_dwe = 0, no acks.
  - Only m0_req set: next state GNT0.
  - Only m1_req set: next state GNT1.
  - Both set: grant goes to the master that is not last_owner.
  - Minimum latency from req to ack is 1 cycle.
- GNTx, cycle with mx_req = 1 (a transfer):
  - Bus carries master x: pdu_daddr = mx_addr, pdu_dwdata = mx_wdata, pdu_dwe = mx_we.
  - mx_ack = 1 combinationally. The other master's ack = 0.
  - Read (mx_we = 0): mx_rdata <= pdu_drdata at the edge; mx_rvalid = 1 for exactly the next cycle.
  - Write: no rvalid.
  - Each transfer increments burst_cnt (8-bit, saturating at 255).
- GNTx, after a transfer, next state:
  - Other master not requesting: stay GNTx. Back-to-back transfers have no bubble.
  - Other master requesting and (mx_lock = 0 or burst_cnt + 1 >= LOCK_MAX): switch to GNTother, burst_cnt <= 0, last_owner <= x.
  - Otherwise (locked and under the limit): stay GNTx.
- GNTx with mx_req = 0 (no transfer):
  - Bus idle: pdu_dwe = 0, address and data driven to 0.
  - Next state: GNTother if the other master is requesting, else IDLE. burst_cnt <= 0, last_owner <= x.
- Lock with the other master not requesting: grant is held without limit. burst_cnt counts, but the limit only forces a switch when the other master is waiting.
- Starvation bound: a waiting master gets its grant within LOCK_MAX + 1 cycles of asserting req.
- mX_rvalid and an ack can be high in the same cycle. Pipelined reads at one per cycle are allowed.
- mX_rdata holds its last value when rvalid = 0.
- Requesters hold req/addr/wdata/we stable until ack. Changing them before ack is illegal and not checked.
- No combinational path from pdu_drdata to any output.

Test Plan:
- Reset, then m0_req = 1 (read, addr 0x4000, pdu_drdata = 0xDEADBEEF) → cycle 1 GNT0 with m0_ack = 1 and pdu_daddr = 0x4000; cycle 2 m0_rvalid = 1, m0_rdata = 0xDEADBEEF.
- Both masters issue continuous unlocked writes (m0 → 0x4000, m1 → 0x8100) → grants alternate 1, 2, 1, 2; first grant to m0; pdu_dwe = 1 each granted cycle; 1 ack per cycle overall.
- LOCK_MAX = 4: m0 locked with continuous writes, m1_req raised mid-burst → m0 gets exactly 4 acks after m1 rises, then GNT1; m1_ack within 5 cycles of req.
- m0 alone, 10 back-to-back reads at 0x4000..0x4024 → 10 consecutive acks, no bubble, 10 rvalid pulses each 1 cycle after its ack with matching data.
- rstn low during a GNT1 write cycle → pdu_dwe = 0 that cycle; next cycle IDLE, grant_id = 0, all rvalid = 0.
- m1 granted, drops req with no m0 request → IDLE next cycle; m1 re-requests → GNT1 after 1 cycle.
